// File: rtl/proc_multicycle_param_if.sv
// Instruction/handshake/bus bundle for proc_multicycle_param.
// The master drives run/ir/din; the processor returns done/busy and the bus value q.
interface proc_multicycle_param_if #(
    parameter int DATA_W   = 16,
    parameter int REG_BITS = 3
);
    logic                    run;
    logic [2+2*REG_BITS:0]   ir;
    logic [DATA_W-1:0]       din;
    logic                    done;
    logic                    busy;
    logic [DATA_W-1:0]       q;

    modport master (output run, ir, din, input done, busy, q);
    modport slave  (input run, ir, din, output done, busy, q);
endinterface

// File: rtl/proc_multicycle_param.sv
// Parametrised multicycle bus processor: eight opcodes sequenced over IDLE/T1/T2/T3
// through a shared bus, register file, accumulator A and result register G.
module proc_multicycle_param #(
    parameter int DATA_W   = 16,
    parameter int REG_BITS = 3
) (
    input  logic                   clock,
    input  logic                   resetn,
    proc_multicycle_param_if.slave bus_if
);
    localparam int NREGS = 2 ** REG_BITS;
    localparam int IR_W  = 3 + 2 * REG_BITS;
    localparam int SH_W  = $clog2(DATA_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_T1   = 2'd1;
    localparam logic [1:0] S_T2   = 2'd2;
    localparam logic [1:0] S_T3   = 2'd3;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_SLL  = 3'b111;

    logic [1:0]          state_q, state_d;
    logic [IR_W-1:0]     ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   g_q, g_d;
    logic [DATA_W-1:0]   regs_q [NREGS];
    logic [DATA_W-1:0]   regs_d [NREGS];
    logic [DATA_W-1:0]   bus;
    logic [DATA_W-1:0]   alu_res;
    logic [2:0]          op;
    logic [REG_BITS-1:0] rx, ry;

    assign op = ir_q[IR_W-1 -: 3];
    assign rx = ir_q[2*REG_BITS-1 -: REG_BITS];
    assign ry = ir_q[REG_BITS-1:0];

    // Bus driver select is kept apart from next-state so the ALU path has no comb loop.
    always_comb begin
        bus = '0;
        case (state_q)
            S_T1: begin
                case (op)
                    OP_MV:   bus = regs_q[ry];
                    OP_MVI:  bus = bus_if.din;
                    OP_MVNZ: if (g_q != '0) bus = regs_q[ry];
                    default: bus = regs_q[rx];
                endcase
            end
            S_T2:    bus = regs_q[ry];
            S_T3:    bus = g_q;
            default: bus = '0;
        endcase
    end

    always_comb begin
        case (op)
            OP_ADD:  alu_res = a_q + bus;
            OP_SUB:  alu_res = a_q - bus;
            OP_AND:  alu_res = a_q & bus;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(bus))};
            OP_SLL:  alu_res = a_q << bus[SH_W-1:0];
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        a_d     = a_q;
        g_d     = g_q;
        regs_d  = regs_q;
        case (state_q)
            S_IDLE: begin
                if (bus_if.run) begin
                    ir_d    = bus_if.ir;
                    state_d = S_T1;
                end
            end
            S_T1: begin
                case (op)
                    OP_MV, OP_MVI: begin
                        regs_d[rx] = bus;
                        state_d    = S_IDLE;
                    end
                    OP_MVNZ: begin
                        if (g_q != '0) regs_d[rx] = bus;
                        state_d = S_IDLE;
                    end
                    default: begin
                        a_d     = bus;
                        state_d = S_T2;
                    end
                endcase
            end
            S_T2: begin
                g_d     = alu_res;
                state_d = S_T3;
            end
            S_T3: begin
                regs_d[rx] = bus;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            a_q     <= '0;
            g_q     <= '0;
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            g_q     <= g_d;
            regs_q  <= regs_d;
        end
    end

    assign bus_if.q    = bus;
    assign bus_if.busy = (state_q != S_IDLE);
    assign bus_if.done = (state_q == S_T3) ||
                         ((state_q == S_T1) && (op == OP_MV || op == OP_MVI || op == OP_MVNZ));
endmodule

// File: tb/tb_proc_multicycle_param.sv
// Scoreboard bench for proc_multicycle_param: 16-bit/8-register and 8-bit/4-register builds.
module tb_proc_multicycle_param;
    logic clock;
    logic resetn;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] sb16 [$];
    logic [15:0] sb8  [$];

    proc_multicycle_param_if #(.DATA_W(16), .REG_BITS(3)) if16 ();
    proc_multicycle_param_if #(.DATA_W(8),  .REG_BITS(2)) if8 ();

    proc_multicycle_param #(.DATA_W(16), .REG_BITS(3)) u16 (
        .clock  (clock),
        .resetn (resetn),
        .bus_if (if16.slave)
    );

    proc_multicycle_param #(.DATA_W(8), .REG_BITS(2)) u8 (
        .clock  (clock),
        .resetn (resetn),
        .bus_if (if8.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every done cycle must correspond to exactly one pending expectation.
    always @(negedge clock) begin
        if (resetn && if16.done) begin
            if (sb16.size() == 0) check_eq("done16_unexpected", 1, 0);
            else check_eq("q16_at_done", {16'h0, if16.q}, {16'h0, sb16.pop_front()});
            check_eq("done16_implies_busy", {31'h0, if16.busy}, 1);
        end
        if (resetn && if8.done) begin
            if (sb8.size() == 0) check_eq("done8_unexpected", 1, 0);
            else check_eq("q8_at_done", {24'h0, if8.q}, {16'h0, sb8.pop_front()});
        end
    end

    task automatic exec(input bit w8, input logic [2:0] op, input int rx, input int ry,
                        input logic [15:0] d, input logic [15:0] expq, input int exp_cyc,
                        input string tag);
        int cyc = 0;
        @(negedge clock); #1;
        if (w8) begin
            if8.run = 1'b1; if8.ir = {op, 2'(rx), 2'(ry)}; if8.din = d[7:0];
            sb8.push_back(expq);
        end else begin
            if16.run = 1'b1; if16.ir = {op, 3'(rx), 3'(ry)}; if16.din = d;
            sb16.push_back(expq);
        end
        @(negedge clock); #1;
        if8.run  = 1'b0;
        if16.run = 1'b0;
        while ((w8 ? if8.busy : if16.busy) && cyc < 10) begin
            cyc++;
            @(negedge clock); #1;
        end
        check_eq({tag, "_busy_cycles"}, 32'(cyc), 32'(exp_cyc));
    endtask

    task automatic rd(input bit w8, input int r, input logic [15:0] expv);
        exec(w8, 3'b000, r, r, 16'h0, expv, 1, "read");
    endtask

    initial begin
        resetn = 1'b0;
        if16.run = 1'b0; if16.ir = '0; if16.din = '0;
        if8.run  = 1'b0; if8.ir  = '0; if8.din  = '0;
        @(negedge clock); #1;
        check_eq("rst_q16",    {16'h0, if16.q}, 0);
        check_eq("rst_busy16", {31'h0, if16.busy}, 0);
        check_eq("rst_done16", {31'h0, if16.done}, 0);
        check_eq("rst_q8",     {24'h0, if8.q}, 0);
        @(negedge clock); #1;
        resetn = 1'b1;

        rd(0, 3, 16'h0000);
        exec(0, 3'b001, 0, 0, 16'h0005, 16'h0005, 1, "mvi_r0");
        rd(0, 0, 16'h0005);

        exec(0, 3'b001, 1, 0, 16'hFFFF, 16'hFFFF, 1, "mvi_r1");
        exec(0, 3'b001, 2, 0, 16'h0002, 16'h0002, 1, "mvi_r2");
        exec(0, 3'b010, 1, 2, 16'h0, 16'h0001, 3, "add_wrap");
        rd(0, 1, 16'h0001);

        exec(0, 3'b001, 3, 0, 16'h0003, 16'h0003, 1, "mvi_r3");
        exec(0, 3'b001, 4, 0, 16'h0005, 16'h0005, 1, "mvi_r4");
        exec(0, 3'b011, 3, 4, 16'h0, 16'hFFFE, 3, "sub_neg");
        exec(0, 3'b101, 3, 4, 16'h0, 16'h0001, 3, "slt_signed");
        exec(0, 3'b100, 4, 1, 16'h0, 16'h0001, 3, "and");
        exec(0, 3'b001, 4, 0, 16'h0005, 16'h0005, 1, "mvi_r4b");

        exec(0, 3'b001, 5, 0, 16'h0001, 16'h0001, 1, "mvi_r5");
        exec(0, 3'b001, 6, 0, 16'h0013, 16'h0013, 1, "mvi_r6");
        exec(0, 3'b111, 5, 6, 16'h0, 16'h0008, 3, "sll_lowbits");

        exec(0, 3'b001, 7, 0, 16'h00AA, 16'h00AA, 1, "mvi_r7");
        exec(0, 3'b011, 4, 4, 16'h0, 16'h0000, 3, "sub_self");
        exec(0, 3'b110, 7, 0, 16'h0, 16'h0000, 1, "mvnz_g0");
        rd(0, 7, 16'h00AA);
        exec(0, 3'b101, 4, 3, 16'h0, 16'h0001, 3, "slt_0_lt_1");
        exec(0, 3'b110, 7, 0, 16'h0, 16'h0005, 1, "mvnz_g1");
        rd(0, 7, 16'h0005);
        exec(0, 3'b010, 2, 2, 16'h0, 16'h0004, 3, "add_alias");

        // run held across done: two reads of R0, one idle cycle between them
        @(negedge clock); #1;
        if16.run = 1'b1; if16.ir = {3'b000, 3'd0, 3'd0};
        sb16.push_back(16'h0005);
        sb16.push_back(16'h0005);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock); #1;
            check_eq("b2b_busy", {31'h0, if16.busy}, (i % 2 == 0) ? 1 : 0);
            if (i == 2) if16.run = 1'b0;
        end

        // run/ir changes during T2 are ignored: R1 (1) + R2 (4) = 5
        @(negedge clock); #1;
        if16.run = 1'b1; if16.ir = {3'b010, 3'd1, 3'd2};
        sb16.push_back(16'h0005);
        @(negedge clock); #1;
        if16.run = 1'b0;
        @(negedge clock); #1;
        if16.run = 1'b1; if16.ir = {3'b001, 3'd1, 3'd1}; if16.din = 16'h0077;
        @(negedge clock); #1;
        if16.run = 1'b0;
        @(negedge clock); #1;
        check_eq("ignore_run_idle", {31'h0, if16.busy}, 0);
        rd(0, 1, 16'h0005);

        // reset asserted in T2 aborts the add and clears everything
        @(negedge clock); #1;
        if16.run = 1'b1; if16.ir = {3'b010, 3'd1, 3'd2};
        @(negedge clock); #1;
        if16.run = 1'b0;
        @(negedge clock); #1;
        resetn = 1'b0;
        #1;
        check_eq("midrst_busy", {31'h0, if16.busy}, 0);
        check_eq("midrst_q",    {16'h0, if16.q}, 0);
        check_eq("midrst_done", {31'h0, if16.done}, 0);
        @(negedge clock); #1;
        resetn = 1'b1;
        rd(0, 1, 16'h0000);
        rd(0, 2, 16'h0000);
        rd(0, 0, 16'h0000);
        exec(0, 3'b001, 0, 0, 16'h1234, 16'h1234, 1, "mvi_post_rst");
        exec(0, 3'b110, 7, 0, 16'h0, 16'h0000, 1, "mvnz_g_cleared");
        rd(0, 7, 16'h0000);

        // 8-bit, 4-register build
        exec(1, 3'b001, 0, 0, 16'h00FF, 16'h00FF, 1, "w8_mvi_r0");
        exec(1, 3'b001, 1, 0, 16'h0001, 16'h0001, 1, "w8_mvi_r1");
        exec(1, 3'b010, 0, 1, 16'h0, 16'h0000, 3, "w8_add_wrap");
        exec(1, 3'b001, 3, 0, 16'h0042, 16'h0042, 1, "w8_mvi_r3");
        rd(1, 3, 16'h0042);
        rd(1, 1, 16'h0001);
        rd(1, 0, 16'h0000);
        exec(1, 3'b111, 3, 0, 16'h0, 16'h0042, 3, "w8_sll_zero");

        repeat (3) @(negedge clock);
        check_eq("sb16_drained", 32'(sb16.size()), 0);
        check_eq("sb8_drained",  32'(sb8.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/proc_multicycle_param.md
Name: proc_multicycle_param

Overview:
- Parametrised successor to the team's 16-bit multicycle bus processor.
- Generalised in data width and register-file depth; the opcode set grows to eight.
- Adds a busy/run handshake, signed compare, shift and conditional move.
- Sits at the top of the lab datapath: external logic presents an instruction on ir and pulses run; the block sequences a shared bus through the register file, accumulator A, ALU and result register G.

Parameters:
- DATA_W, 16, width of the bus, registers, A, G and din.
- REG_BITS, 3, register-index width; NREGS = 2**REG_BITS registers R0..R(NREGS-1).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- run  in  1  start request; sampled only in IDLE.
- ir  in  3+2*REG_BITS  instruction {op[2:0], rx, ry}; sampled into the internal IR when run is accepted.
- din  in  DATA_W  immediate data for mvi; sampled during mvi T1.
- done  out  1  high during the final cycle of each instruction.
- busy  out  1  high whenever the FSM is not in IDLE.
- q  out  DATA_W  current bus value.

Behaviour:
- Reset (resetn=0, asynchronous):
  - FSM goes to IDLE; IR, A, G and all Rn clear to 0.
  - done=0, busy=0, q=0.
  - Asserting reset mid-instruction aborts it; no partial write survives.
- Bus:
  - Single driver per cycle, selected from Rn, G or din.
  - When no driver is selected the bus is 0, so q=0 in IDLE.
- FSM states: IDLE, T1, T2, T3.
  - IDLE with run=1: latch ir into IR, go to T1 next edge.
  - IDLE with run=0: stay in IDLE.
  - run while busy=1 is ignored; ir changes after acceptance have no effect.
- Opcodes and step actions (Rx/Ry = register indexed by IR rx/ry):
  - 000 mv: T1: bus=Ry, Rx<=bus, done. Back to IDLE.
  - 001 mvi: T1: bus=din, Rx<=bus, done. Back to IDLE.
  - 010 add, 011 sub, 100 and, 101 slt, 111 sll:
    - T1: bus=Rx, A<=bus.
    - T2: bus=Ry, G<=ALU(A, bus).
    - T3: bus=G, Rx<=bus, done. Back to IDLE.
  - 110 mvnz: T1: if G!=0 then bus=Ry, Rx<=bus; else no write, bus=0. done either way. Back to IDLE.
- ALU:
  - add/sub: modulo 2**DATA_W; carry and borrow discarded.
  - and: bitwise AND.
  - slt: signed two's-complement A<Ry gives 1, else 0, zero-extended.
  - sll: A shifted left by the low clog2(DATA_W) bits of Ry; upper Ry bits ignored; zero fill.
- Latency from the accepting edge to the register-write edge:
  - mv/mvi/mvnz: 1 cycle.
  - ALU ops: 3 cycles.
- Back-to-back: run held high across the done cycle is accepted on the first IDLE cycle, giving one idle cycle between instructions.
- Aliasing:
  - rx==ry is legal: add R1,R1 doubles R1.
  - G is updated only by ALU ops; mv/mvi/mvnz leave G unchanged.
- done and busy are Moore outputs decoded from the state and IR opcode; done implies busy.

Test Plan:
- Reset then mvi R0 with din=16'h0005 -> q=16'h0005 in T1, done=1 for one cycle, R0=5; with resetn low, q=0 and busy=0.
- mvi R1=16'hFFFF, mvi R2=16'h0002, add R1,R2 -> T3 q=16'h0001 (wrap), done in T3 only, 3 cycles busy.
- sub R3,R4 with R3=3, R4=5 -> R3=16'hFFFE; then slt R3,R4 -> R3=1 (signed -2<5).
- sll R5,R6 with R5=1, R6=16'h0013 (DATA_W=16, shift 3) -> R5=8.
- mvnz R7,R0 after G=0 (e.g. sub of equal values) -> R7 unchanged; after G=1 -> R7=R0.
- Pulse run and change ir during T2 of an add -> ignored, result unaffected. Drop resetn in T2 -> all regs 0 and FSM in IDLE. Rebuild with DATA_W=8, REG_BITS=2 -> 8-bit wrap 8'hFF+1=0 and 4-register addressing.
